// File: rtl/processor_control_fsm.sv
// processor_control_fsm: multi-cycle control sequencer for the 16-bit processor datapath.
// Ports:
//   clk, state_reset (async active-low)  - clock and reset
//   start, mem_ready, instr, LT_flag     - run request, RAM handshake, RAM read data, less-than flag
//   state                                - current FSM state (IDLE..HALT)
//   PC_EN .. EN_output                   - datapath enables, selects and ALU control
//   illegal_op, halted, instr_count      - status: bad opcode pulse, halt flag, retired count
module processor_control_fsm #(
    parameter int IW   = 16,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            state_reset,
    input  logic            start,
    input  logic            mem_ready,
    input  logic [IW-1:0]   instr,
    input  logic            LT_flag,
    output logic [2:0]      state,
    output logic            PC_EN,
    output logic            branch_len,
    output logic            PC_or_read_mem,
    output logic            read_1EN,
    output logic            read_2EN,
    output logic            reg_file_wrEN,
    output logic            Altwrsel,
    output logic            lineb_ex,
    output logic [1:0]      alu_control,
    output logic            LT_flag_set,
    output logic            EN_mem_add,
    output logic            RAM_rddisEN,
    output logic            RAM_wrEN,
    output logic            EN_output,
    output logic            illegal_op,
    output logic            halted,
    output logic [CNTW-1:0] instr_count
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    typedef struct packed {
        logic       pc_en, branch_len, pc_or_read_mem, read_1en, read_2en, reg_file_wren, altwrsel, lineb_ex;
        logic [1:0] alu_control;
        logic       lt_flag_set, en_mem_add, ram_rd, ram_wr, en_output, illegal_op, halted;
    } ctl_t;

    localparam logic [3:0] OP_NOP = 4'h0, OP_ADD = 4'h1, OP_OR = 4'h4, OP_ADDI = 4'h5, OP_LOAD = 4'h6;
    localparam logic [3:0] OP_STORE = 4'h7, OP_CMP = 4'h8, OP_BLT = 4'h9, OP_JMP = 4'hA, OP_OUT = 4'hB, OP_HALT = 4'hF;

    state_t     st, ns;
    logic [3:0] ir, op_n;
    logic       illegal, retire;
    ctl_t       ctl;

    // Only the opcode field steers the sequencer; operand bits belong to the datapath.
    logic unused_operand;
    assign unused_operand = ^instr[IW-5:0];

    // Control word for a given state/opcode; registered so outputs are glitch-free.
    function automatic ctl_t dec(state_t s, logic [3:0] op, logic lt);
        ctl_t c;
        c = '0;
        case (s)
            FETCH:  c.ram_rd = 1'b1;
            DECODE: begin
                c.read_1en   = 1'b1;
                c.read_2en   = 1'b1;
                c.pc_en      = 1'b1;
                c.illegal_op = op inside {4'hC, 4'hD, 4'hE};
            end
            EXEC: begin
                // ADD..OR map to alu codes 00..11 as opcode-1
                c.alu_control = (op inside {[OP_ADD:OP_OR]}) ? op[1:0] - 2'd1 : (op == OP_CMP) ? 2'b01 : 2'b00;
                c.lineb_ex    = op inside {OP_ADDI, OP_LOAD, OP_STORE};
                c.en_mem_add  = op inside {OP_LOAD, OP_STORE};
                c.lt_flag_set = op == OP_CMP;
                c.branch_len  = op == OP_JMP || (op == OP_BLT && lt);
                c.pc_en       = c.branch_len;
                c.en_output   = op == OP_OUT;
            end
            MEM: begin
                c.pc_or_read_mem = 1'b1;
                c.ram_rd         = op == OP_LOAD;
                c.ram_wr         = op == OP_STORE;
            end
            WB: begin
                c.reg_file_wren = 1'b1;
                c.altwrsel      = op == OP_LOAD;
            end
            HALT:    c.halted = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        op_n    = (st == FETCH && mem_ready) ? instr[IW-1:IW-4] : ir;
        illegal = ir inside {4'hC, 4'hD, 4'hE};
        case (st)
            IDLE:    ns = start ? FETCH : IDLE;
            FETCH:   ns = mem_ready ? DECODE : FETCH;
            DECODE:  ns = (ir == OP_NOP || illegal) ? FETCH : (ir == OP_HALT) ? HALT : EXEC;
            EXEC:    ns = (ir inside {[OP_ADD:OP_ADDI]}) ? WB : (ir inside {OP_LOAD, OP_STORE}) ? MEM : FETCH;
            MEM:     ns = !mem_ready ? MEM : (ir == OP_LOAD) ? WB : FETCH;
            WB:      ns = FETCH;
            HALT:    ns = start ? FETCH : HALT;
            default: ns = IDLE;
        endcase
        // An instruction retires when it hands back to FETCH (illegal ones excluded) or halts.
        retire = (((st == DECODE && !illegal) || st == EXEC || st == MEM || st == WB) && ns == FETCH)
               || (ns == HALT && st != HALT);
    end

    always_ff @(posedge clk or negedge state_reset) begin
        if (!state_reset) begin
            st          <= IDLE;
            ir          <= '0;
            instr_count <= '0;
            ctl         <= '0;
        end else begin
            st  <= ns;
            ir  <= op_n;
            ctl <= dec(ns, op_n, LT_flag);
            if (retire) instr_count <= instr_count + 1'b1;
        end
    end

    assign state          = st;
    assign PC_EN          = ctl.pc_en;
    assign branch_len     = ctl.branch_len;
    assign PC_or_read_mem = ctl.pc_or_read_mem;
    assign read_1EN       = ctl.read_1en;
    assign read_2EN       = ctl.read_2en;
    assign reg_file_wrEN  = ctl.reg_file_wren;
    assign Altwrsel       = ctl.altwrsel;
    assign lineb_ex       = ctl.lineb_ex;
    assign alu_control    = ctl.alu_control;
    assign LT_flag_set    = ctl.lt_flag_set;
    assign EN_mem_add     = ctl.en_mem_add;
    assign RAM_rddisEN    = ctl.ram_rd;
    assign RAM_wrEN       = ctl.ram_wr;
    assign EN_output      = ctl.en_output;
    assign illegal_op     = ctl.illegal_op;
    assign halted         = ctl.halted;
endmodule

// File: tb/tb_processor_control_fsm.sv
// tb_processor_control_fsm: randomized instruction stream checked against an instruction-level model.
module tb_processor_control_fsm;
    localparam int IW = 16;
    localparam int CW = 4;

    logic          clk = 1'b0, state_reset = 1'b0, start = 1'b0, mem_ready = 1'b0, LT_flag = 1'b0;
    logic [IW-1:0] instr = '0;
    logic [2:0]    state;
    logic          PC_EN, branch_len, PC_or_read_mem, read_1EN, read_2EN, reg_file_wrEN, Altwrsel, lineb_ex;
    logic [1:0]    alu_control;
    logic          LT_flag_set, EN_mem_add, RAM_rddisEN, RAM_wrEN, EN_output, illegal_op, halted;
    logic [CW-1:0] instr_count;

    processor_control_fsm #(.IW(IW), .CNTW(CW)) dut (
        .clk(clk), .state_reset(state_reset), .start(start), .mem_ready(mem_ready), .instr(instr),
        .LT_flag(LT_flag), .state(state), .PC_EN(PC_EN), .branch_len(branch_len),
        .PC_or_read_mem(PC_or_read_mem), .read_1EN(read_1EN), .read_2EN(read_2EN),
        .reg_file_wrEN(reg_file_wrEN), .Altwrsel(Altwrsel), .lineb_ex(lineb_ex),
        .alu_control(alu_control), .LT_flag_set(LT_flag_set), .EN_mem_add(EN_mem_add),
        .RAM_rddisEN(RAM_rddisEN), .RAM_wrEN(RAM_wrEN), .EN_output(EN_output),
        .illegal_op(illegal_op), .halted(halted), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int vectors = 0, errors = 0;
    int a_pc, a_br, a_prm, a_r1, a_r2, a_wr, a_alt, a_lb, a_alu, a_lts, a_ma, a_rd, a_ramwr, a_out, a_ill, a_hlt;
    logic [CW-1:0] cnt_m = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [16:0] all_outs();
        return {PC_EN, branch_len, PC_or_read_mem, read_1EN, read_2EN, reg_file_wrEN, Altwrsel, lineb_ex,
                alu_control, LT_flag_set, EN_mem_add, RAM_rddisEN, RAM_wrEN, EN_output, illegal_op, halted};
    endfunction

    // One clock: check state/count at the negedge, tally outputs, drive inputs for the next edge.
    task automatic cyc(input logic [2:0] es, input logic mr, input logic [IW-1:0] ins, input logic st,
                       input logic [CW-1:0] ec);
        check("state", 32'(state), 32'(es));
        check("count", 32'(instr_count), 32'(ec));
        a_pc += int'(PC_EN); a_br += int'(branch_len); a_prm += int'(PC_or_read_mem);
        a_r1 += int'(read_1EN); a_r2 += int'(read_2EN); a_wr += int'(reg_file_wrEN);
        a_alt += int'(Altwrsel); a_lb += int'(lineb_ex); a_alu += int'(alu_control);
        a_lts += int'(LT_flag_set); a_ma += int'(EN_mem_add); a_rd += int'(RAM_rddisEN);
        a_ramwr += int'(RAM_wrEN); a_out += int'(EN_output); a_ill += int'(illegal_op); a_hlt += int'(halted);
        mem_ready = mr;
        instr     = ins;
        start     = st;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    // Runs one instruction from its first FETCH cycle and checks per-instruction output totals.
    task automatic run_instr(input logic [3:0] op, input int wf, input int wm, input int h, input logic lt);
        logic [CW-1:0] c0;
        logic          ill, mem_op, br;
        int            exp_alu;
        c0     = cnt_m;
        ill    = op inside {4'hC, 4'hD, 4'hE};
        mem_op = op inside {4'h6, 4'h7};
        br     = op == 4'hA || (op == 4'h9 && lt);
        exp_alu = (op >= 4'h1 && op <= 4'h4) ? int'(op) - 1 : (op == 4'h8) ? 1 : 0;
        {a_pc, a_br, a_prm, a_r1, a_r2, a_wr, a_alt, a_lb, a_alu, a_lts, a_ma, a_rd, a_ramwr, a_out, a_ill, a_hlt} = '0;
        LT_flag = lt;
        for (int i = 0; i < wf; i++) cyc(3'd1, 1'b0, IW'($urandom), rb(), c0);
        cyc(3'd1, 1'b1, {op, 12'($urandom)}, rb(), c0);
        cyc(3'd2, rb(), IW'($urandom), rb(), c0);
        if (op == 4'hF) begin
            for (int i = 0; i < h; i++) cyc(3'd6, rb(), IW'($urandom), 1'b0, CW'(c0 + 1));
            cyc(3'd6, rb(), IW'($urandom), 1'b1, CW'(c0 + 1));
        end else if (op != 4'h0 && !ill) begin
            cyc(3'd3, rb(), IW'($urandom), rb(), c0);
            if (mem_op) begin
                for (int i = 0; i < wm; i++) cyc(3'd4, 1'b0, IW'($urandom), rb(), c0);
                cyc(3'd4, 1'b1, IW'($urandom), rb(), c0);
            end
            if (op >= 4'h1 && op <= 4'h6) cyc(3'd5, rb(), IW'($urandom), rb(), c0);
        end
        cnt_m = ill ? c0 : CW'(c0 + 1);
        check("ram_rd_cycles", a_rd, wf + 1 + (op == 4'h6 ? wm + 1 : 0));
        check("ram_wr_cycles", a_ramwr, op == 4'h7 ? wm + 1 : 0);
        check("pc_or_mem_cycles", a_prm, mem_op ? wm + 1 : 0);
        check("read_en", {a_r1, a_r2}, {32'd1, 32'd1});
        check("pc_en_cycles", a_pc, 1 + int'(br));
        check("branch_len", a_br, int'(br));
        check("rf_wr", a_wr, (op >= 4'h1 && op <= 4'h6) ? 1 : 0);
        check("altwrsel", a_alt, op == 4'h6 ? 1 : 0);
        check("lineb_ex", a_lb, (op >= 4'h5 && op <= 4'h7) ? 1 : 0);
        check("alu_control", a_alu, exp_alu);
        check("lt_flag_set", a_lts, op == 4'h8 ? 1 : 0);
        check("en_mem_add", a_ma, mem_op ? 1 : 0);
        check("en_output", a_out, op == 4'hB ? 1 : 0);
        check("illegal_op", a_ill, int'(ill));
        check("halted_cycles", a_hlt, op == 4'hF ? h + 1 : 0);
    endtask

    initial begin
        #12;
        check("reset_state", 32'(state), 0);
        check("reset_count", 32'(instr_count), 0);
        check("reset_outs", 32'(all_outs()), 0);
        @(negedge clk);
        state_reset = 1'b1;
        cyc(3'd0, 1'b1, '0, 1'b0, '0);
        check("idle_outs", 32'(all_outs()), 0);
        cyc(3'd0, 1'b1, '0, 1'b1, '0);
        run_instr(4'h1, 0, 0, 0, 1'b0);
        run_instr(4'h6, 0, 3, 0, 1'b0);
        run_instr(4'h8, 1, 0, 0, 1'b1);
        run_instr(4'h9, 0, 0, 0, 1'b1);
        run_instr(4'h8, 0, 0, 0, 1'b0);
        run_instr(4'h9, 0, 0, 0, 1'b0);
        run_instr(4'hC, 0, 0, 0, 1'b0);
        run_instr(4'hF, 0, 0, 10, 1'b0);
        run_instr(4'h7, 2, 2, 0, 1'b0);
        for (int n = 0; n < 150; n++)
            run_instr(4'($urandom), $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3), rb());
        // Asynchronous reset while a STORE waits in MEM.
        LT_flag = 1'b0;
        cyc(3'd1, 1'b1, 16'h7000, 1'b0, cnt_m);
        cyc(3'd2, 1'b1, '0, 1'b0, cnt_m);
        cyc(3'd3, 1'b0, '0, 1'b0, cnt_m);
        check("mem_state", 32'(state), 4);
        check("wr_before_reset", 32'(RAM_wrEN), 1);
        #2 state_reset = 1'b0;
        #1;
        check("wr_after_reset", 32'(RAM_wrEN), 0);
        check("state_after_reset", 32'(state), 0);
        check("count_after_reset", 32'(instr_count), 0);
        check("outs_after_reset", 32'(all_outs()), 0);
        @(negedge clk);
        check("state_held_reset", 32'(state), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/processor_control_fsm.md
Name: processor_control_fsm

Overview:
- Multi-cycle control sequencer for the 16-bit processor datapath (PC, register file, ALU, memory-address register, RAM, output register).
- Latches each instruction fetched from RAM and decodes the 4-bit opcode.
- Drives every datapath enable, select and ALU control through IDLE/FETCH/DECODE/EXEC/MEM/WB/HALT.
- Supports RAM wait states via mem_ready and keeps a retired-instruction counter.

Parameters:
- IW, 16, instruction width; opcode = instr[IW-1:IW-4].
- CNTW, 16, width of retired-instruction counter.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- state_reset  in  1  asynchronous, active-low reset.
- start  in  1  leave IDLE or HALT and begin fetching.
- mem_ready  in  1  RAM access completes this cycle.
- instr  in  IW  RAM read data (Mem_out); captured into IR at end of FETCH.
- LT_flag  in  1  datapath less-than flag.
- state  out  3  IDLE=000 FETCH=001 DECODE=010 EXEC=011 MEM=100 WB=101 HALT=110.
- PC_EN  out  1  PC load.
- branch_len  out  1  PC loads branch target instead of PC+1.
- PC_or_read_mem  out  1  RAM address source: 0=PC, 1=mem-address register.
- read_1EN, read_2EN  out  1 each  register-file read enables.
- reg_file_wrEN  out  1  register-file write.
- Altwrsel  out  1  write-back source: 1=RAM data, 0=ALU.
- lineb_ex  out  1  ALU B input = sign-extended immediate.
- alu_control  out  2  00 add, 01 sub, 10 and, 11 or.
- LT_flag_set  out  1  capture LT flag from ALU.
- EN_mem_add  out  1  load mem-address register.
- RAM_rddisEN  out  1  RAM read enable.
- RAM_wrEN  out  1  RAM write enable.
- EN_output  out  1  load output register.
- illegal_op  out  1  one-cycle pulse on undefined opcode.
- halted  out  1  high while in HALT.
- instr_count  out  CNTW  retired instructions.

Behaviour:
- Reset (async, state_reset=0): state=IDLE, IR=0, instr_count=0, every output 0. Applies mid-instruction, including during a pending RAM access.
- Outputs default to 0. Each state asserts only what is listed below; outputs decode from state and IR opcode (Moore).
- Opcodes:
  - 0 NOP; 1 ADD; 2 SUB; 3 AND; 4 OR; 5 ADDI; 6 LOAD; 7 STORE; 8 CMP; 9 BLT; A JMP; B OUT; F HALT.
  - C, D, E are illegal.
- IDLE: all outputs 0. start=1 -> FETCH.
- FETCH: RAM_rddisEN=1, PC_or_read_mem=0. Stays in FETCH while mem_ready=0. When mem_ready=1: IR<=instr, go to DECODE.
- DECODE: read_1EN=read_2EN=1, PC_EN=1 (PC+1).
  - NOP -> FETCH.
  - Illegal -> illegal_op=1, then FETCH.
  - HALT -> HALT.
  - All other opcodes -> EXEC.
- EXEC:
  - ADD/SUB/AND/OR: alu_control=opcode-1 -> WB.
  - ADDI: alu_control=00, lineb_ex=1 -> WB.
  - LOAD/STORE: alu_control=00, lineb_ex=1, EN_mem_add=1 -> MEM.
  - CMP: alu_control=01, LT_flag_set=1 -> FETCH.
  - BLT: branch_len=PC_EN=LT_flag -> FETCH.
  - JMP: branch_len=PC_EN=1 -> FETCH.
  - OUT: EN_output=1 -> FETCH.
- MEM: PC_or_read_mem=1; LOAD asserts RAM_rddisEN, STORE asserts RAM_wrEN. Enable is held every cycle until mem_ready=1. Then LOAD -> WB, STORE -> FETCH.
- WB: reg_file_wrEN=1; Altwrsel=1 for LOAD, 0 otherwise -> FETCH.
- HALT: halted=1. start=1 -> FETCH; otherwise stays.
- Retire: instr_count increments by 1 on the cycle the FSM leaves DECODE/EXEC/MEM/WB back to FETCH, or enters HALT.
  - Illegal opcodes are not counted.
  - Counter wraps 2^CNTW-1 -> 0.
- Latency with mem_ready constantly 1:
  - NOP, HALT: 2 cycles.
  - CMP/BLT/JMP/OUT/STORE: 3 cycles; STORE adds its MEM cycle (4 total).
  - ALU/ADDI: 4 cycles.
  - LOAD: 5 cycles.
  - Each mem_ready=0 cycle adds one cycle.
- start is ignored outside IDLE/HALT.

Test Plan:
- Reset, then start=1, instr=0x1xxx, mem_ready=1 -> states 001,010,011,101,001; alu_control=00 in EXEC; reg_file_wrEN high exactly 1 cycle in WB; instr_count=1.
- LOAD 0x6xxx with mem_ready low 3 cycles in MEM -> RAM_rddisEN and PC_or_read_mem high 4 cycles; WB has Altwrsel=1; total 8 cycles.
- CMP then BLT with LT_flag=1 -> EXEC of CMP has LT_flag_set=1, alu_control=01; EXEC of BLT has branch_len=PC_EN=1. Repeat with LT_flag=0 -> both 0.
- instr=0xC000 -> illegal_op 1-cycle pulse in DECODE; returns to FETCH; instr_count unchanged.
- HALT 0xF000 -> halted=1, state=110 held 10 cycles with start=0; start=1 -> FETCH; instr_count incremented once.
- Assert state_reset=0 mid-MEM of STORE (between clock edges) -> RAM_wrEN drops immediately; state=000; instr_count=0.
